// File: rtl/i2c_slave_regbank_ctrl_pkg.sv
// Shared types and defaults for the I2C slave register-bank controller.
package i2c_slave_regbank_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [7:0] ZERO8       = 8'h00;
  localparam int         AW_DEF      = 4;
  localparam int         RO_BASE_DEF = 12;
endpackage

// File: rtl/i2c_edge_det.sv
// Registered edge detector: one sync flop, then rise/fall against the previous sample.
module i2c_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic s_q, last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q    <= 1'b0;
      last_q <= 1'b0;
    end else begin
      s_q    <= in_i;
      last_q <= s_q;
    end
  end

  assign lvl_o  = s_q;
  assign rise_o = s_q & ~last_q;
  assign fall_o = ~s_q & last_q;
endmodule

// File: rtl/i2c_slave_regbank_ctrl.sv
// I2C slave byte-engine sequencer sharing a single-port register bank with a host port.
// Optional sticky write-event interrupt under `I2C_REGBANK_IRQ_EN.
module i2c_slave_regbank_ctrl
  import i2c_slave_regbank_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int RO_BASE = RO_BASE_DEF
) (
`ifdef I2C_REGBANK_IRQ_EN
  output logic          irq,
  input  logic          irq_clr,
`endif
  input  logic          clk,
  input  logic          reset,
  input  logic          i2c_active,
  input  logic          received,
  input  logic [7:0]    datareceive,
  input  logic          sended,
  output logic [7:0]    datasend,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [7:0]    h_wdata,
  output logic [7:0]    h_rdata,
  output logic          h_ack
);
  localparam int          DEPTH  = 2**AW;
  localparam logic [AW:0] RO_LIM = (AW+1)'(RO_BASE);

  logic [7:0]    mem_q [DEPTH];
  state_e        st_q, st_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [7:0]    ds_q, ds_d, rdata_q;
  logic          ack_q, i2c_we, i2c_bank, h_grant, ptr_wr_ok;

  logic act_lvl, act_rise, act_fall, rx_rise, tx_rise;
  logic rx_lvl_unused, rx_fall_unused, tx_lvl_unused, tx_fall_unused;
  logic [7:0] rx_byte_unused;

  assign rx_byte_unused = datareceive;

  i2c_edge_det u_act (.clk(clk), .reset(reset), .in_i(i2c_active),
                      .lvl_o(act_lvl), .rise_o(act_rise), .fall_o(act_fall));
  i2c_edge_det u_rx  (.clk(clk), .reset(reset), .in_i(received),
                      .lvl_o(rx_lvl_unused), .rise_o(rx_rise), .fall_o(rx_fall_unused));
  i2c_edge_det u_tx  (.clk(clk), .reset(reset), .in_i(sended),
                      .lvl_o(tx_lvl_unused), .rise_o(tx_rise), .fall_o(tx_fall_unused));

  assign ptr_inc   = ptr_q + AW'(1);
  assign ptr_wr_ok = ({1'b0, ptr_q} < RO_LIM);

  always_ff @(posedge clk) begin
    if (!reset) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (!act_lvl) st_d = ST_IDLE;
    else begin
      case (st_q)
        ST_IDLE: if (act_rise) st_d = ST_PTR;
        ST_PTR:  if (rx_rise)  st_d = ST_DATA;
        default: ;
      endcase
    end
  end

  // received wins over sended if both rise together; i2c_bank marks a bank access this cycle
  always_comb begin
    ptr_d    = ptr_q;
    ds_d     = ds_q;
    i2c_we   = 1'b0;
    i2c_bank = 1'b0;
    if (act_lvl) begin
      case (st_q)
        ST_IDLE: if (act_rise) begin
          ds_d     = mem_q[ptr_q];
          i2c_bank = 1'b1;
        end
        ST_PTR, ST_DATA: begin
          if (rx_rise) begin
            if (st_q == ST_PTR) begin
              ptr_d    = datareceive[AW-1:0];
              ds_d     = mem_q[datareceive[AW-1:0]];
              i2c_bank = 1'b1;
            end else begin
              ptr_d    = ptr_inc;
              i2c_we   = ptr_wr_ok;
              i2c_bank = ptr_wr_ok;
            end
          end else if (tx_rise) begin
            ptr_d    = ptr_inc;
            ds_d     = mem_q[ptr_inc];
            i2c_bank = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ack_q blocks a second grant while the host still holds its request
  assign h_grant = h_req & ~ack_q & ~i2c_bank;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      ds_q    <= ZERO8;
      rdata_q <= ZERO8;
      ack_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ZERO8;
    end else begin
      ptr_q <= ptr_d;
      ds_q  <= ds_d;
      ack_q <= h_grant;
      if (h_grant && !h_we) rdata_q <= mem_q[h_addr];
      if (h_grant && h_we)  mem_q[h_addr] <= h_wdata;
      if (i2c_we)           mem_q[ptr_q]  <= datareceive;
    end
  end

  assign datasend = ds_q;
  assign h_rdata  = rdata_q;
  assign h_ack    = ack_q;

`ifdef I2C_REGBANK_IRQ_EN
  logic irq_q, wr_seen_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      if (act_fall && wr_seen_q) irq_q <= 1'b1;
      else if (irq_clr)          irq_q <= 1'b0;
      if (act_fall || act_rise)  wr_seen_q <= 1'b0;
      else if (i2c_we)           wr_seen_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  logic act_fall_unused;
  assign act_fall_unused = act_fall;
`endif
endmodule

// File: tb/tb_i2c_slave_regbank_ctrl.sv
// Directed self-checking bench for i2c_slave_regbank_ctrl (IRQ checks when I2C_REGBANK_IRQ_EN is defined).
module tb_i2c_slave_regbank_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, i2c_active, received, sended;
  logic [7:0]    datareceive, datasend;
  logic          h_req, h_we, h_ack;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_wdata, h_rdata;
`ifdef I2C_REGBANK_IRQ_EN
  logic          irq, irq_clr;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  i2c_slave_regbank_ctrl #(.AW(AW), .RO_BASE(12)) dut (
`ifdef I2C_REGBANK_IRQ_EN
    .irq(irq), .irq_clr(irq_clr),
`endif
    .clk(clk), .reset(reset), .i2c_active(i2c_active), .received(received),
    .datareceive(datareceive), .sended(sended), .datasend(datasend),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_ack(h_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx(input logic [7:0] b);
    datareceive = b; received = 1'b1; tick(4);
    received = 1'b0; tick(4);
  endtask

  task automatic tx();
    sended = 1'b1; tick(4);
    sended = 1'b0; tick(4);
  endtask

  task automatic act(input logic v);
    i2c_active = v; tick(4);
  endtask

  task automatic host(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int lat);
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d; lat = 0;
    do begin tick(); lat++; end while (!h_ack && lat < 20);
    if (!h_ack) chk("host_timeout", 32'd0, 32'd1);
    rd = h_rdata;
    h_req = 1'b0; tick();
  endtask

  task automatic hwr(input logic [AW-1:0] a, input logic [7:0] d);
    logic [7:0] rd; int lat;
    host(1'b1, a, d, rd, lat);
  endtask

  task automatic hrd_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    logic [7:0] rd; int lat;
    host(1'b0, a, 8'h00, rd, lat);
    chk(tag, 32'(rd), 32'(exp));
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    reset = 1'b0; i2c_active = 1'b0; received = 1'b0; sended = 1'b0;
    datareceive = 8'h00; h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = 8'h00;
`ifdef I2C_REGBANK_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick(3);
    reset = 1'b1; tick(2);
    chk("rst_datasend", 32'(datasend), 32'h00);
    chk("rst_h_ack",    32'(h_ack),    32'h0);
    chk("rst_h_rdata",  32'(h_rdata),  32'h00);
    chk("rst_ptr",      32'(dut.ptr_q), 32'h0);
`ifdef I2C_REGBANK_IRQ_EN
    chk("rst_irq", 32'(irq), 32'h0);
`endif

    // 1: pointer + two data bytes
    act(1'b1); rx(8'h03); rx(8'hA5); rx(8'h5A); act(1'b0);
    chk("wr_ptr", 32'(dut.ptr_q), 32'h5);
    hrd_chk("wr_mem3", 4'd3, 8'hA5);
    hrd_chk("wr_mem4", 4'd4, 8'h5A);

    // 2: combined read with repeated start
    host(1'b1, 4'd2, 8'h11, rd, lat);
    chk("host_wr_lat", 32'(lat), 32'd1);
    hwr(4'd3, 8'h22); hwr(4'd4, 8'h33); hwr(4'd5, 8'h44);
    act(1'b1);
    chk("rd_resume", 32'(datasend), 32'h44);
    rx(8'h02);
    chk("rd_ptr_load", 32'(datasend), 32'h11);
    act(1'b0); act(1'b1);
    chk("rd_sr", 32'(datasend), 32'h11);
    tx(); chk("rd_seq1", 32'(datasend), 32'h22);
    tx(); chk("rd_seq2", 32'(datasend), 32'h33);
    tx(); chk("rd_seq3", 32'(datasend), 32'h44);
    act(1'b0);

    // 3: RO drop and pointer wrap
    hwr(4'd15, 8'h99);
    act(1'b1); rx(8'h0F);
    chk("ro_ptr_ds", 32'(datasend), 32'h99);
    rx(8'h77); rx(8'h88); act(1'b0);
    chk("wrap_ptr", 32'(dut.ptr_q), 32'h1);
    hrd_chk("ro_mem15", 4'd15, 8'h99);
    hrd_chk("wrap_mem0", 4'd0, 8'h88);

    // 4: host write collides with an I2C write to the same address
    act(1'b1); rx(8'h04);
    datareceive = 8'h3C; received = 1'b1; tick();
    host(1'b1, 4'd4, 8'hC3, rd, lat);
    received = 1'b0; tick(4);
    act(1'b0);
    chk("cont_lat", 32'(lat), 32'd2);
    hrd_chk("cont_mem4", 4'd4, 8'hC3);

    // 5: reset between pointer and data byte
    act(1'b1); rx(8'h07);
    reset = 1'b0; tick(2);
    chk("mid_rst_ds",  32'(datasend),   32'h00);
    chk("mid_rst_ptr", 32'(dut.ptr_q),  32'h0);
    chk("mid_rst_ack", 32'(h_ack),      32'h0);
    reset = 1'b1; tick(4);
    hrd_chk("mid_rst_mem4", 4'd4, 8'h00);
    hwr(4'd9, 8'h5E);
    rx(8'h09);
    chk("post_rst_ptr", 32'(dut.ptr_q), 32'h9);
    chk("post_rst_ds",  32'(datasend),  32'h5E);
    act(1'b0);

`ifdef I2C_REGBANK_IRQ_EN
    // 6: interrupt on write transactions only
    act(1'b1); rx(8'h01); rx(8'h12); act(1'b0);
    chk("irq_set", 32'(irq), 32'h1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0; tick();
    chk("irq_clr", 32'(irq), 32'h0);
    act(1'b1); rx(8'h0D); rx(8'h55); act(1'b0);
    chk("irq_ro_only", 32'(irq), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
